// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides, an accumulator and
// zero/carry flags. Stage 1 captures the operand beat; stage 2 computes and holds the result.
module alu_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       opcode,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_out,
    output logic             zero,
    output logic             carry,
    output logic             a_is_zero,
    output logic [WIDTH-1:0] acc_q
);

    localparam logic [2:0] OpPassA = 3'b000;
    localparam logic [2:0] OpSub   = 3'b001;
    localparam logic [2:0] OpAdd   = 3'b010;
    localparam logic [2:0] OpAnd   = 3'b011;
    localparam logic [2:0] OpXor   = 3'b100;
    localparam logic [2:0] OpPassB = 3'b101;
    localparam logic [2:0] OpOr    = 3'b110;
    localparam logic [2:0] OpAcc   = 3'b111;

    // Stage 1 state
    logic             s1_valid_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic [2:0]       s1_op_q;

    // Stage 2 (output) state
    logic             out_valid_q;
    logic [WIDTH-1:0] alu_out_q;
    logic             zero_q;
    logic             carry_q;
    logic             a_is_zero_q;
    logic [WIDTH-1:0] acc_reg_q;

    // Handshake
    logic s2_free;
    logic s1_adv;
    logic in_fire;

    assign s2_free  = !out_valid_q || out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign in_fire  = in_valid && in_ready;

    // Datapath
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH:0]   acc_ext;
    logic [WIDTH-1:0] res_d;
    logic             carry_d;

    // A clear landing with an advancing ACC beat takes effect before the accumulate.
    assign acc_base = acc_clr ? '0 : acc_reg_q;
    assign sum_ext  = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    assign diff_ext = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    assign acc_ext  = {1'b0, acc_base} + {1'b0, s1_a_q};

    always_comb begin
        res_d   = '0;
        carry_d = 1'b0;
        unique case (s1_op_q)
            OpPassA: res_d = s1_a_q;
            OpSub: begin
                res_d   = diff_ext[WIDTH-1:0];
                carry_d = diff_ext[WIDTH];
            end
            OpAdd: begin
                res_d   = sum_ext[WIDTH-1:0];
                carry_d = sum_ext[WIDTH];
            end
            OpAnd:   res_d = s1_a_q & s1_b_q;
            OpXor:   res_d = s1_a_q ^ s1_b_q;
            OpPassB: res_d = s1_b_q;
            OpOr:    res_d = s1_a_q | s1_b_q;
            OpAcc: begin
                res_d   = acc_ext[WIDTH-1:0];
                carry_d = acc_ext[WIDTH];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
        end else if (in_fire) begin
            s1_valid_q <= 1'b1;
            s1_a_q     <= in_a;
            s1_b_q     <= in_b;
            s1_op_q    <= opcode;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            alu_out_q   <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            a_is_zero_q <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q <= 1'b1;
            alu_out_q   <= res_d;
            zero_q      <= (res_d == '0);
            carry_q     <= carry_d;
            a_is_zero_q <= (s1_a_q == '0);
        end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Accumulator moves only when an ACC beat actually enters stage 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_reg_q <= '0;
        end else if (s1_adv && (s1_op_q == OpAcc)) begin
            acc_reg_q <= acc_ext[WIDTH-1:0];
        end else if (acc_clr) begin
            acc_reg_q <= '0;
        end
    end

    assign out_valid = out_valid_q;
    assign alu_out   = alu_out_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign a_is_zero = a_is_zero_q;
    assign acc_q     = acc_reg_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: the driver pushes model results on acceptance, a monitor
// pops and compares on every output transfer and checks stall stability.
module tb_alu_pipe;

    localparam int W = 8;
    localparam int M = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic [2:0]   opcode;
    logic         acc_clr;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] alu_out;
    logic         zero;
    logic         carry;
    logic         a_is_zero;
    logic [W-1:0] acc_q;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .opcode    (opcode),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_out   (alu_out),
        .zero      (zero),
        .carry     (carry),
        .a_is_zero (a_is_zero),
        .acc_q     (acc_q)
    );

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         c;
        logic         az;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   model_acc = 0;
    int   ready_mode = 0;  // 0: always ready, 1: random, 2: held low

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, accumulator applied in beat order.
    function automatic exp_t model(input int a, input int b, input int op);
        exp_t e;
        int   r;
        int   c;
        c = 0;
        case (op)
            0: r = a;
            1: begin r = a - b; c = (a < b) ? 1 : 0; end
            2: begin r = a + b; c = (r >= M) ? 1 : 0; end
            3: r = a & b;
            4: r = a ^ b;
            5: r = b;
            6: r = a | b;
            default: begin
                r = model_acc + a;
                c = (r >= M) ? 1 : 0;
                model_acc = r % M;
            end
        endcase
        r     = ((r % M) + M) % M;
        e.res = W'(r);
        e.z   = (r == 0);
        e.c   = c[0];
        e.az  = (a == 0);
        return e;
    endfunction

    always @(negedge clk) begin
        case (ready_mode)
            0: out_ready <= 1'b1;
            1: out_ready <= 1'($urandom_range(0, 1));
            default: out_ready <= 1'b0;
        endcase
    end

    task automatic send(input int a, input int b, input int op);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = W'(a);
        in_b     = W'(b);
        opcode   = 3'(op);
        #1;
        while (!in_ready) begin
            @(negedge clk);
            #1;
            guard++;
            if (guard > 200) begin
                $display("FAIL send_timeout: got in_ready %0b expected 1", in_ready);
                $fatal(1, "input stalled");
            end
        end
        sb.push_back(model(a, b, op));
    endtask

    task automatic drain();
        int g;
        g = 0;
        @(negedge clk);
        in_valid = 1'b0;
        acc_clr  = 1'b0;
        #3;
        while ((sb.size() != 0 || out_valid) && g < 300) begin
            @(negedge clk);
            #3;
            g++;
        end
        check("drain_timeout", sb.size(), 0);
    endtask

    task automatic rand_beat();
        int a;
        a = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, M - 1));
        send(a, int'($urandom_range(0, M - 1)), int'($urandom_range(0, 7)));
    endtask

    // Monitor: compare on transfer, require held outputs across a stall.
    logic         stall_prev = 1'b0;
    logic [W+2:0] prev_out;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (stall_prev) begin
                    check("hold_valid", 32'(out_valid), 1);
                    check("hold_data", 32'({alu_out, zero, carry, a_is_zero}), 32'(prev_out));
                end
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("spurious_out", 32'(out_valid), 0);
                    end else begin
                        e = sb.pop_front();
                        check("alu_out", 32'(alu_out), 32'(e.res));
                        check("zero", 32'(zero), 32'(e.z));
                        check("carry", 32'(carry), 32'(e.c));
                        check("a_is_zero", 32'(a_is_zero), 32'(e.az));
                    end
                end
                stall_prev = out_valid && !out_ready;
                prev_out   = {alu_out, zero, carry, a_is_zero};
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
        opcode   = '0;
        acc_clr  = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #3;
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_alu_out", 32'(alu_out), 0);
        check("rst_flags", 32'({zero, carry, a_is_zero}), 0);
        check("rst_acc_q", 32'(acc_q), 0);
        check("rst_in_ready", 32'(in_ready), 1);

        // ADD with carry, two-cycle latency
        send(8'hF0, 8'h20, 2);
        @(negedge clk);
        in_valid = 1'b0;
        #3;
        check("lat_early", 32'(out_valid), 0);
        @(negedge clk);
        #3;
        check("lat_valid", 32'(out_valid), 1);
        check("add_res", 32'(alu_out), 32'h10);
        check("add_carry", 32'(carry), 1);
        check("add_zero", 32'(zero), 0);
        drain();

        // SUB borrow and zero
        send(3, 5, 1);
        send(7, 7, 1);
        drain();

        // Accumulate chain after clear
        @(negedge clk);
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr   = 1'b0;
        model_acc = 0;
        send(1, 9, 7);
        send(2, 9, 7);
        send(3, 9, 7);
        drain();
        check("acc_chain", 32'(acc_q), 6);

        // Clear coinciding with an advancing ACC beat
        model_acc = 0;
        send(4, 0, 7);
        @(negedge clk);
        in_valid = 1'b0;
        acc_clr  = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
        drain();
        check("acc_clr_same", 32'(acc_q), 4);

        // Backpressure: stream while output is held
        ready_mode = 2;
        fork
            begin
                for (int i = 0; i < 6; i++) send(16 * i + 1, i, 2);
            end
        join_none
        repeat (5) @(negedge clk);
        #3;
        check("stall_in_ready", 32'(in_ready), 0);
        check("stall_held", sb.size(), 2);
        check("stall_valid", 32'(out_valid), 1);
        ready_mode = 0;
        wait fork;
        drain();

        // Random traffic with random backpressure, acc cleared between rounds
        for (int round = 0; round < 2; round++) begin
            ready_mode = 1;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                end else begin
                    rand_beat();
                end
            end
            ready_mode = 0;
            drain();
            check("rand_acc", 32'(acc_q), 32'(model_acc));
            @(negedge clk);
            acc_clr = 1'b1;
            @(negedge clk);
            acc_clr   = 1'b0;
            model_acc = 0;
        end

        // Reset with two beats in flight
        send(1, 2, 2);
        send(3, 4, 2);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        sb.delete();
        model_acc = 0;
        #3;
        check("flush_valid", 32'(out_valid), 0);
        check("flush_alu_out", 32'(alu_out), 0);
        check("flush_flags", 32'({zero, carry, a_is_zero}), 0);
        check("flush_acc", 32'(acc_q), 0);
        check("flush_in_ready", 32'(in_ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #3;
            check("flush_no_out", 32'(out_valid), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
